// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM state encoding, parity type codes
// and the expected-parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Expected parity bit given the XOR-reduction of the data word.
  function automatic logic exp_parity(input logic data_xor, input logic par_typ);
    logic r;
    case (par_typ)
      PAR_EVEN: r = data_xor;
      PAR_ODD:  r = ~data_xor;
      default:  r = data_xor;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side UART bundle: serial line and framing controls in,
// recovered word and status strobes out. The slave modport is the receiver.
interface uart_rx_if #(
  parameter int DATA_W = 8
);
  logic              RX_IN;
  logic              PAR_EN;
  logic              PAR_TYP;
  logic [DATA_W-1:0] P_DATA;
  logic              DATA_VLD;
  logic              PAR_ERR;
  logic              STP_ERR;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP,
    input  P_DATA, DATA_VLD, PAR_ERR, STP_ERR
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP,
    output P_DATA, DATA_VLD, PAR_ERR, STP_ERR
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// Bit-centre sampler for the UART receiver. With UART_RX_MAJORITY_EN defined
// it captures three samples around the bit centre and votes 2-of-3; otherwise
// it captures a single sample at the centre tick. The captured value is valid
// by the last tick of the bit, where the FSM consumes it.
module data_sampler #(
  parameter int OVERSAMPLE = 8,
  parameter int CNT_W      = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             rx_s,
  input  logic [CNT_W-1:0] edge_cnt,
  output logic             sampled_bit
);

  localparam logic [CNT_W-1:0] MID = CNT_W'(OVERSAMPLE / 2);

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CNT_W-1:0] MID_LO = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID_HI = CNT_W'(OVERSAMPLE / 2 + 1);

  logic [2:0] samp_q;

  // Capture the line at the three ticks surrounding the bit centre.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_q <= 3'b111;
    end else begin
      if (edge_cnt == MID_LO) samp_q[0] <= rx_s;
      if (edge_cnt == MID)    samp_q[1] <= rx_s;
      if (edge_cnt == MID_HI) samp_q[2] <= rx_s;
    end
  end

  assign sampled_bit = (samp_q[0] & samp_q[1]) |
                       (samp_q[0] & samp_q[2]) |
                       (samp_q[1] & samp_q[2]);
`else
  logic samp_q;

  // Capture the line once, at the bit centre.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      samp_q <= 1'b1;
    end else if (edge_cnt == MID) begin
      samp_q <= rx_s;
    end
  end

  assign sampled_bit = samp_q;
`endif

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start-bit qualification, LSB-first
// data shift, optional parity and stop check, one-cycle result strobes.
// Build option: UART_RX_MAJORITY_EN selects 2-of-3 majority bit sampling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic     CLK,
  input  logic     RST,
  uart_rx_if.slave bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] EDGE_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);

  logic [1:0]        sync_q;
  rx_state_e         state_q;
  logic [CNT_W-1:0]  edge_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] p_data_q;
  logic              par_en_q;
  logic              par_typ_q;
  logic              par_bad_q;
  logic              data_vld_q;
  logic              par_err_q;
  logic              stp_err_q;

  logic rx_s;
  logic bit_end_s;
  logic sampled_bit_s;

  // Two-flop synchronizer; reset to the idle line level.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], bus.RX_IN};
    end
  end

  assign rx_s      = sync_q[1];
  assign bit_end_s = (edge_cnt_q == EDGE_LAST);

  data_sampler #(
    .OVERSAMPLE (OVERSAMPLE),
    .CNT_W      (CNT_W)
  ) u_sampler (
    .CLK         (CLK),
    .RST         (RST),
    .rx_s        (rx_s),
    .edge_cnt    (edge_cnt_q),
    .sampled_bit (sampled_bit_s)
  );

  // Frame FSM with counters, shift register, parity check and output strobes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= RX_IDLE;
      edge_cnt_q <= {CNT_W{1'b0}};
      bit_cnt_q  <= {BIT_W{1'b0}};
      shift_q    <= {DATA_W{1'b0}};
      p_data_q   <= {DATA_W{1'b0}};
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      data_vld_q <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;

      if (state_q != RX_IDLE) begin
        edge_cnt_q <= bit_end_s ? {CNT_W{1'b0}} : edge_cnt_q + CNT_W'(1);
      end

      case (state_q)
        RX_IDLE: begin
          // The detecting cycle is tick 0 of the start bit.
          if (!rx_s) begin
            state_q    <= RX_START;
            edge_cnt_q <= CNT_W'(1);
            bit_cnt_q  <= {BIT_W{1'b0}};
            par_en_q   <= bus.PAR_EN;
            par_typ_q  <= bus.PAR_TYP;
            par_bad_q  <= 1'b0;
          end
        end
        RX_START: begin
          if (bit_end_s) begin
            state_q <= sampled_bit_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_end_s) begin
            shift_q <= {sampled_bit_s, shift_q[DATA_W-1:1]};
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q <= {BIT_W{1'b0}};
              state_q   <= par_en_q ? RX_PARITY : RX_STOP;
            end else begin
              bit_cnt_q <= bit_cnt_q + BIT_W'(1);
            end
          end
        end
        RX_PARITY: begin
          if (bit_end_s) begin
            par_bad_q <= (sampled_bit_s != exp_parity(^shift_q, par_typ_q));
            state_q   <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (bit_end_s) begin
            state_q   <= RX_IDLE;
            par_err_q <= par_bad_q;
            stp_err_q <= ~sampled_bit_s;
            if (!par_bad_q && sampled_bit_s) begin
              data_vld_q <= 1'b1;
              p_data_q   <= shift_q;
            end
          end
        end
        default: begin
          state_q <= RX_IDLE;
        end
      endcase
    end
  end

  assign bus.P_DATA   = p_data_q;
  assign bus.DATA_VLD = data_vld_q;
  assign bus.PAR_ERR  = par_err_q;
  assign bus.STP_ERR  = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed, table-driven bench for uart_rx (DATA_W=8, OVERSAMPLE=8).
module tb_uart_rx;
  import uart_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  uart_rx_if #(.DATA_W(8)) bus ();

  uart_rx #(.DATA_W(8), .OVERSAMPLE(8)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam logic [7:0] GLITCH_EXP = 8'hF7;
`endif

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_typ;
    logic       par_flip;
    logic       stop_bit;
    logic       glitch;
    logic       toggle;
    int         exp_vld;
    int         exp_perr;
    int         exp_serr;
    logic [7:0] exp_pdata;
    int         exp_lat;
  } vec_t;

  vec_t vecs[8];

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor state, sampled on the falling edge.
  int         cyc = 0;
  int         vld_cnt = 0;
  int         perr_cnt = 0;
  int         serr_cnt = 0;
  int         pulse_cyc = 0;
  int         vld_cyc = 0;
  int         prev_vld_cyc = 0;
  logic [7:0] vld_data = 8'h00;
  logic [7:0] prev_vld_data = 8'h00;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.DATA_VLD) begin
      vld_cnt       <= vld_cnt + 1;
      prev_vld_cyc  <= vld_cyc;
      vld_cyc       <= cyc;
      prev_vld_data <= vld_data;
      vld_data      <= bus.P_DATA;
    end
    if (bus.PAR_ERR) perr_cnt <= perr_cnt + 1;
    if (bus.STP_ERR) serr_cnt <= serr_cnt + 1;
    if (bus.DATA_VLD || bus.PAR_ERR || bus.STP_ERR) pulse_cyc <= cyc;
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // One bit cell of 8 ticks; optional one-tick low glitch at tick 4.
  task automatic drive_bit(input logic b, input logic glitch);
    for (int m = 0; m < 8; m++) begin
      bus.RX_IN = (glitch && m == 4) ? 1'b0 : b;
      tick(1);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic par_en,
                            input logic par_typ, input logic par_flip,
                            input logic stop_bit, input logic glitch,
                            input logic toggle, output int start_cyc);
    bus.PAR_EN  = par_en;
    bus.PAR_TYP = par_typ;
    start_cyc   = cyc;
    drive_bit(1'b0, 1'b0);
    if (toggle) begin
      bus.PAR_EN  = ~par_en;
      bus.PAR_TYP = ~par_typ;
    end
    for (int i = 0; i < 8; i++) drive_bit(data[i], glitch && (i == 3));
    if (par_en) drive_bit((^data) ^ par_typ ^ par_flip, 1'b0);
    drive_bit(stop_bit, 1'b0);
    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = par_en;
    bus.PAR_TYP = par_typ;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, st2;
    int v0, p0, s0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'hA5, 82};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'h3C, 90};
    vecs[2] = '{8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 0, 8'h3C, 90};
    vecs[3] = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 0, 8'h01, 90};
    vecs[4] = '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1, 8'h01, 82};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 0, GLITCH_EXP, 82};
    vecs[6] = '{8'h96, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1, GLITCH_EXP, 90};
    vecs[7] = '{8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0, 0, 8'hA5, 82};

    bus.RX_IN   = 1'b1;
    bus.PAR_EN  = 1'b0;
    bus.PAR_TYP = 1'b0;
    RST = 1'b0;
    tick(3);
    check("rst_p_data",   int'(bus.P_DATA),   0);
    check("rst_data_vld", int'(bus.DATA_VLD), 0);
    check("rst_par_err",  int'(bus.PAR_ERR),  0);
    check("rst_stp_err",  int'(bus.STP_ERR),  0);
    RST = 1'b1;
    tick(5);

    for (int i = 0; i < 8; i++) begin
      v0 = vld_cnt; p0 = perr_cnt; s0 = serr_cnt;
      send_frame(vecs[i].data, vecs[i].par_en, vecs[i].par_typ, vecs[i].par_flip,
                 vecs[i].stop_bit, vecs[i].glitch, vecs[i].toggle, st);
      tick(6);
      check($sformatf("v%0d_vld", i),   vld_cnt - v0,  vecs[i].exp_vld);
      check($sformatf("v%0d_perr", i),  perr_cnt - p0, vecs[i].exp_perr);
      check($sformatf("v%0d_serr", i),  serr_cnt - s0, vecs[i].exp_serr);
      check($sformatf("v%0d_pdata", i), int'(bus.P_DATA), int'(vecs[i].exp_pdata));
      check($sformatf("v%0d_lat", i),   pulse_cyc - st, vecs[i].exp_lat);
      tick(4);
    end

    // Start glitch: two low ticks must be rejected silently.
    v0 = vld_cnt; p0 = perr_cnt; s0 = serr_cnt;
    bus.PAR_EN = 1'b0;
    bus.RX_IN  = 1'b0;
    tick(2);
    bus.RX_IN  = 1'b1;
    tick(20);
    check("glitch_vld",  vld_cnt - v0,  0);
    check("glitch_perr", perr_cnt - p0, 0);
    check("glitch_serr", serr_cnt - s0, 0);
    check("glitch_idle", int'(dut.state_q), int'(RX_IDLE));

    // Back-to-back frames with no idle gap.
    v0 = vld_cnt;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, st);
    send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, st2);
    tick(6);
    check("b2b_count", vld_cnt - v0, 2);
    check("b2b_gap",   vld_cyc - prev_vld_cyc, 80);
    check("b2b_data0", int'(prev_vld_data), 8'h55);
    check("b2b_data1", int'(vld_data), 8'hAA);
    check("b2b_lat",   vld_cyc - st2, 82);
    check("b2b_first", prev_vld_cyc - st, 82);
    tick(4);

    // Reset asserted in the middle of data bit 4.
    bus.PAR_EN = 1'b0;
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0], 1'b0);
    bus.RX_IN = 1'b1;
    tick(3);
    RST = 1'b0;
    #1;
    check("mid_rst_p_data",   int'(bus.P_DATA),   0);
    check("mid_rst_data_vld", int'(bus.DATA_VLD), 0);
    check("mid_rst_par_err",  int'(bus.PAR_ERR),  0);
    check("mid_rst_stp_err",  int'(bus.STP_ERR),  0);
    check("mid_rst_idle",     int'(dut.state_q),  int'(RX_IDLE));
    tick(3);
    RST = 1'b1;
    tick(10);
    v0 = vld_cnt; p0 = perr_cnt; s0 = serr_cnt;
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, st);
    tick(6);
    check("post_rst_vld",   vld_cnt - v0, 1);
    check("post_rst_err",   (perr_cnt - p0) + (serr_cnt - s0), 0);
    check("post_rst_data",  int'(vld_data), 8'hC3);
    check("post_rst_pdata", int'(bus.P_DATA), 8'hC3);
    check("post_rst_lat",   vld_cyc - st, 82);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
